fast_div: RTL and testbench
===========================

Name: fast_div

Overview:
- Sequential unsigned divider; the inverse operation of the team's lookup-table fast multiplier.
- Takes an 8-bit dividend and a 4-bit divisor and returns the quotient and remainder, so that dividend = quotient*divisor + remainder.
- Uses a restoring shift-subtract datapath, one quotient bit per cycle, with valid/ready handshakes on both sides.
- Sits beside the multiplier in the arithmetic examples and is checked against it: (q*d + r) must equal the dividend.

Parameters:
- DIVIDEND_W, 8, dividend and quotient width; also the iteration count.
- DIVISOR_W, 4, divisor and remainder width; must be less than or equal to DIVIDEND_W.

Ports:
- clk  input  1  clock; all flops rise-edge.
- reset  input  1  asynchronous, active-low reset.
- io_in_valid  input  1  request valid.
- io_in_ready  output  1  block can accept a request.
- io_in_dividend  input  DIVIDEND_W  unsigned dividend.
- io_in_divisor  input  DIVISOR_W  unsigned divisor.
- io_out_valid  output  1  result valid.
- io_out_ready  input  1  consumer accepts the result.
- io_out_quotient  output  DIVIDEND_W  quotient.
- io_out_remainder  output  DIVISOR_W  remainder.
- io_out_divzero  output  1  divisor was zero.

Behaviour:
- Reset (reset low, asynchronous):
  - State goes to IDLE.
  - io_in_ready=1, io_out_valid=0.
  - quotient, remainder and divzero registers are cleared to 0.
  - Reset asserted mid-operation abandons the operation; no result is produced.
- States: IDLE, BUSY, DONE.
- IDLE:
  - io_in_ready=1.
  - On io_in_valid, capture dividend into shift register Q, divisor into D, clear partial remainder R (DIVISOR_W+1 bits) and set counter to DIVIDEND_W-1.
  - If divisor==0: go directly to DONE with quotient=all ones, remainder=0, divzero=1. Latency is 1 cycle.
  - Otherwise go to BUSY.
- BUSY:
  - io_in_ready=0.
  - Each cycle:
    - T = {R[DIVISOR_W-1:0], Q[msb]}.
    - If T >= D: R = T - D and shift 1 into Q lsb.
    - Else: R = T and shift 0 into Q lsb.
    - Q shifts left by one.
  - After the iteration where counter==0, go to DONE.
  - Exactly DIVIDEND_W BUSY cycles.
- DONE:
  - io_out_valid=1.
  - quotient=Q, remainder=R[DIVISOR_W-1:0], divzero as latched.
  - Outputs hold stable while io_out_valid=1 and io_out_ready=0 (back-pressure of any length).
  - On io_out_ready: go to IDLE and deassert io_out_valid on the next cycle.
  - Result outputs keep their last values in IDLE; they are don't-care and are not checked.
- Latency:
  - Acceptance edge to io_out_valid high is DIVIDEND_W+1 cycles for a nonzero divisor and 1 cycle for divisor==0.
  - Throughput: one operation at a time, with no overlap.
  - io_in_ready is low in BUSY and DONE, so a request arriving during an operation waits; it is neither dropped nor latched.
- Arithmetic:
  - Fully unsigned.
  - Remainder is always less than the divisor.
  - Quotient may use all DIVIDEND_W bits (e.g. divisor=1).
  - R never exceeds 2*D-1, so DIVISOR_W+1 bits cannot overflow.
- Inputs are sampled only on the acceptance edge; later changes to the input bus have no effect.

Test Plan:
- Reset: hold reset low with io_in_valid=1 -> io_in_ready=1, io_out_valid=0, all outputs 0. Release reset -> request accepted on the first edge.
- Basic: dividend=0xE1, divisor=0xF -> after 9 cycles, quotient=0x0F, remainder=0x0, divzero=0. Then dividend=200, divisor=13 -> quotient=0x0F, remainder=0x5.
- Boundaries:
  - 0xFF/0x1 -> q=0xFF, r=0.
  - 0xFF/0xF -> q=0x11, r=0.
  - 0x00/0x7 -> q=0, r=0.
  - 0x0E/0xF -> q=0, r=0xE.
- Divide by zero: 0x5A/0x0 -> io_out_valid one cycle after acceptance; q=0xFF, r=0, divzero=1.
- Back-pressure: 0xFF/0x7 with io_out_ready=0 for 5 cycles -> q=0x24, r=0x3 held stable and io_in_ready=0 throughout. Raise io_out_ready -> valid drops next cycle; a new request is accepted the following cycle.
- Mid-operation reset and exhaustive check:
  - Assert reset 3 cycles into BUSY -> state returns to IDLE immediately and no io_out_valid appears.
  - Then sweep all 4096 dividend/divisor pairs with random io_out_ready -> q*d+r==dividend and r<d for every nonzero d.

Source files
------------

// File: rtl/fast_div.sv
// Sequential unsigned restoring divider: one quotient bit per cycle, valid/ready on both sides.
// A zero divisor short-circuits to an all-ones quotient with the divzero flag set.
module fast_div #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  io_in_valid,
  output logic                  io_in_ready,
  input  logic [DIVIDEND_W-1:0] io_in_dividend,
  input  logic [DIVISOR_W-1:0]  io_in_divisor,
  output logic                  io_out_valid,
  input  logic                  io_out_ready,
  output logic [DIVIDEND_W-1:0] io_out_quotient,
  output logic [DIVISOR_W-1:0]  io_out_remainder,
  output logic                  io_out_divzero
);

  localparam int CW = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [DIVIDEND_W-1:0] q_sh;
  logic [DIVISOR_W-1:0]  d_reg;
  // The partial remainder stays below D, so its top bit is always zero and is not stored.
  logic [DIVISOR_W-1:0]  r_reg;
  logic [DIVISOR_W:0]    t;
  logic                  qbit;
  logic [DIVISOR_W-1:0]  r_next;
  logic [DIVIDEND_W-1:0] q_next;

  // One restoring step: returns {quotient bit, new partial remainder}.
  function automatic logic [DIVISOR_W:0] restore_step(input logic [DIVISOR_W:0]   tv,
                                                      input logic [DIVISOR_W-1:0] dv);
    logic [DIVISOR_W-1:0] diff;
    diff = tv[DIVISOR_W-1:0] - dv;
    if (tv >= {1'b0, dv}) return {1'b1, diff};
    else                  return {1'b0, tv[DIVISOR_W-1:0]};
  endfunction

  always_comb begin
    t              = {r_reg, q_sh[DIVIDEND_W-1]};
    {qbit, r_next} = restore_step(t, d_reg);
    q_next         = (q_sh << 1) | DIVIDEND_W'(qbit);
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && io_in_valid) begin
      q_sh  <= io_in_dividend;
      d_reg <= io_in_divisor;
      r_reg <= '0;
    end else if (state == BUSY) begin
      q_sh  <= q_next;
      r_reg <= r_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      cnt              <= '0;
      io_in_ready      <= 1'b1;
      io_out_valid     <= 1'b0;
      io_out_quotient  <= '0;
      io_out_remainder <= '0;
      io_out_divzero   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (io_in_valid) begin
            cnt         <= CW'(DIVIDEND_W - 1);
            io_in_ready <= 1'b0;
            if (io_in_divisor == '0) begin
              state            <= DONE;
              io_out_valid     <= 1'b1;
              io_out_quotient  <= '1;
              io_out_remainder <= '0;
              io_out_divzero   <= 1'b1;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            state            <= DONE;
            io_out_valid     <= 1'b1;
            io_out_quotient  <= q_next;
            io_out_remainder <= r_next;
            io_out_divzero   <= 1'b0;
          end
        end
        DONE: begin
          if (io_out_ready) begin
            state        <= IDLE;
            io_out_valid <= 1'b0;
            io_in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fast_div.sv
// Bench for fast_div: directed scenarios plus a full dividend/divisor sweep checked
// against plain integer division.
module tb_fast_div;

  logic       clk = 1'b0;
  logic       reset;
  logic       io_in_valid;
  logic       io_in_ready;
  logic [7:0] io_in_dividend;
  logic [3:0] io_in_divisor;
  logic       io_out_valid;
  logic       io_out_ready;
  logic [7:0] io_out_quotient;
  logic [3:0] io_out_remainder;
  logic       io_out_divzero;

  int total = 0;
  int bad   = 0;

  fast_div #(.DIVIDEND_W(8), .DIVISOR_W(4)) dut (
    .clk(clk), .reset(reset),
    .io_in_valid(io_in_valid), .io_in_ready(io_in_ready),
    .io_in_dividend(io_in_dividend), .io_in_divisor(io_in_divisor),
    .io_out_valid(io_out_valid), .io_out_ready(io_out_ready),
    .io_out_quotient(io_out_quotient), .io_out_remainder(io_out_remainder),
    .io_out_divzero(io_out_divzero)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_q(input int a, input int d);
    return (d == 0) ? 8'hFF : 8'(a / d);
  endfunction

  function automatic logic [3:0] ref_r(input int a, input int d);
    return (d == 0) ? 4'h0 : 4'(a % d);
  endfunction

  // Called and returning at a negedge; drives one request through its acceptance edge.
  task automatic start_op(input logic [7:0] a, input logic [3:0] d);
    int guard = 0;
    while (io_in_ready !== 1'b1 && guard < 50) begin
      @(posedge clk); @(negedge clk); guard++;
    end
    if (guard >= 50) begin
      total++; bad++;
      $display("FAIL ready_wait: io_in_ready=%b, required 1 within 50 cycles", io_in_ready);
    end
    io_in_valid = 1'b1; io_in_dividend = a; io_in_divisor = d;
    @(posedge clk);
    @(negedge clk);
    io_in_valid = 1'b0;
    io_in_dividend = 8'($urandom);
    io_in_divisor  = 4'($urandom);
  endtask

  // Latency counts clock edges starting with the acceptance edge as 1.
  task automatic wait_result(output int lat);
    lat = 1;
    while (io_out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); @(negedge clk); lat++;
    end
  endtask

  task automatic release_out;
    io_out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    io_out_ready = 1'b0;
  endtask

  task automatic test_reset;
    int lat;
    reset = 1'b0; io_in_valid = 1'b1; io_in_dividend = 8'h12; io_in_divisor = 4'h3;
    io_out_ready = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (io_in_ready !== 1'b1 || io_out_valid !== 1'b0) begin
      bad++; $display("FAIL reset_hs: ready=%b valid=%b, required 1/0", io_in_ready, io_out_valid);
    end
    total++;
    if (io_out_quotient !== 8'h00 || io_out_remainder !== 4'h0 || io_out_divzero !== 1'b0) begin
      bad++; $display("FAIL reset_out: q=%h r=%h z=%b, required 00/0/0",
                      io_out_quotient, io_out_remainder, io_out_divzero);
    end
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    io_in_valid = 1'b0;
    total++;
    if (io_in_ready !== 1'b0) begin
      bad++; $display("FAIL reset_first_accept: ready=%b, required 0", io_in_ready);
    end
    wait_result(lat);
    total++;
    if (lat != 9 || io_out_quotient !== 8'h06 || io_out_remainder !== 4'h0) begin
      bad++; $display("FAIL reset_first_op: lat=%0d q=%h r=%h, required 9/06/0",
                      lat, io_out_quotient, io_out_remainder);
    end
    release_out();
  endtask

  task automatic run_table(input string name, input logic [7:0] ta[], input logic [3:0] td[]);
    int lat;
    for (int i = 0; i < ta.size(); i++) begin
      start_op(ta[i], td[i]);
      wait_result(lat);
      total++;
      if (lat != 9 || io_out_quotient !== ref_q(ta[i], td[i]) ||
          io_out_remainder !== ref_r(ta[i], td[i]) || io_out_divzero !== 1'b0) begin
        bad++;
        $display("FAIL %s %h/%h: lat=%0d q=%h r=%h z=%b, required 9/%h/%h/0", name, ta[i], td[i],
                 lat, io_out_quotient, io_out_remainder, io_out_divzero,
                 ref_q(ta[i], td[i]), ref_r(ta[i], td[i]));
      end
      total++;
      if (int'(io_out_quotient) * int'(td[i]) + int'(io_out_remainder) != int'(ta[i])) begin
        bad++; $display("FAIL %s_identity %h/%h: q=%h r=%h", name, ta[i], td[i],
                        io_out_quotient, io_out_remainder);
      end
      release_out();
      total++;
      if (io_out_valid !== 1'b0 || io_in_ready !== 1'b1) begin
        bad++; $display("FAIL %s_release: valid=%b ready=%b, required 0/1", name,
                        io_out_valid, io_in_ready);
      end
    end
  endtask

  task automatic test_basic;
    logic [7:0] ta[] = '{8'hE1, 8'd200};
    logic [3:0] td[] = '{4'hF, 4'd13};
    run_table("basic", ta, td);
  endtask

  task automatic test_boundaries;
    logic [7:0] ta[] = '{8'hFF, 8'hFF, 8'h00, 8'h0E};
    logic [3:0] td[] = '{4'h1, 4'hF, 4'h7, 4'hF};
    run_table("boundary", ta, td);
  endtask

  task automatic test_divzero;
    int lat;
    start_op(8'h5A, 4'h0);
    wait_result(lat);
    total++;
    if (lat != 1 || io_out_quotient !== 8'hFF || io_out_remainder !== 4'h0 ||
        io_out_divzero !== 1'b1) begin
      bad++; $display("FAIL divzero: lat=%0d q=%h r=%h z=%b, required 1/FF/0/1",
                      lat, io_out_quotient, io_out_remainder, io_out_divzero);
    end
    release_out();
  endtask

  task automatic test_back_pressure;
    int lat;
    start_op(8'hFF, 4'h7);
    wait_result(lat);
    // A second request waits on the bus for the whole stall.
    io_in_valid = 1'b1; io_in_dividend = 8'h64; io_in_divisor = 4'h3;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); @(negedge clk);
      total++;
      if (io_out_valid !== 1'b1 || io_in_ready !== 1'b0 || io_out_quotient !== 8'h24 ||
          io_out_remainder !== 4'h3) begin
        bad++; $display("FAIL bp_hold cyc%0d: valid=%b ready=%b q=%h r=%h, required 1/0/24/3",
                        k, io_out_valid, io_in_ready, io_out_quotient, io_out_remainder);
      end
    end
    io_out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    io_out_ready = 1'b0;
    total++;
    if (io_out_valid !== 1'b0 || io_in_ready !== 1'b1) begin
      bad++; $display("FAIL bp_release: valid=%b ready=%b, required 0/1", io_out_valid, io_in_ready);
    end
    @(posedge clk); @(negedge clk);
    io_in_valid = 1'b0;
    total++;
    if (io_in_ready !== 1'b0) begin
      bad++; $display("FAIL bp_next_accept: ready=%b, required 0", io_in_ready);
    end
    wait_result(lat);
    total++;
    if (lat != 9 || io_out_quotient !== 8'h21 || io_out_remainder !== 4'h1) begin
      bad++; $display("FAIL bp_next_result: lat=%0d q=%h r=%h, required 9/21/1",
                      lat, io_out_quotient, io_out_remainder);
    end
    release_out();
  endtask

  task automatic test_mid_reset;
    bit seen = 1'b0;
    start_op(8'hAB, 4'h5);
    repeat (3) begin @(posedge clk); @(negedge clk); end
    reset = 1'b0;
    #1;
    total++;
    if (io_in_ready !== 1'b1 || io_out_valid !== 1'b0) begin
      bad++; $display("FAIL midreset_async: ready=%b valid=%b, required 1/0", io_in_ready, io_out_valid);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); @(negedge clk);
      if (io_out_valid !== 1'b0) seen = 1'b1;
    end
    total++;
    if (seen || io_in_ready !== 1'b1) begin
      bad++; $display("FAIL midreset_no_result: valid_seen=%b ready=%b, required 0/1", seen, io_in_ready);
    end
  endtask

  task automatic test_sweep;
    int lat, hold;
    logic [7:0] q0;
    logic [3:0] r0;
    logic       z0;
    for (int a = 0; a < 256; a++) begin
      for (int d = 0; d < 16; d++) begin
        start_op(8'(a), 4'(d));
        wait_result(lat);
        q0 = io_out_quotient; r0 = io_out_remainder; z0 = io_out_divzero;
        total++;
        if (lat != ((d == 0) ? 1 : 9) || q0 !== ref_q(a, d) || r0 !== ref_r(a, d) ||
            z0 !== (d == 0)) begin
          bad++; $display("FAIL sweep %0d/%0d: lat=%0d q=%h r=%h z=%b, required %0d/%h/%h/%b",
                          a, d, lat, q0, r0, z0, (d == 0) ? 1 : 9, ref_q(a, d), ref_r(a, d), d == 0);
        end
        if (d != 0) begin
          total++;
          if (int'(q0) * d + int'(r0) != a || int'(r0) >= d) begin
            bad++; $display("FAIL sweep_identity %0d/%0d: q=%h r=%h", a, d, q0, r0);
          end
        end
        hold = $urandom_range(0, 2);
        for (int k = 0; k < hold; k++) begin
          @(posedge clk); @(negedge clk);
          total++;
          if (io_out_valid !== 1'b1 || io_out_quotient !== q0 || io_out_remainder !== r0 ||
              io_out_divzero !== z0) begin
            bad++; $display("FAIL sweep_hold %0d/%0d: valid=%b q=%h r=%h z=%b", a, d,
                            io_out_valid, io_out_quotient, io_out_remainder, io_out_divzero);
          end
        end
        release_out();
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_divzero();
    test_back_pressure();
    test_mid_reset();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
